// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: 2-flop synchronizer, 16x tick generator and a single FSM
// that samples start/data/stop bits mid-bit and presents bytes via valid/ack.
module uart_rx_ctrl #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       DataIn,
  input  logic       rdAck,
  output logic [7:0] DataOut,
  output logic       charRX,
  output logic       frameErr,
  output logic       overrun,
  output logic       busy
);

  localparam int DIV = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_n;
  logic            sync1, rx_s;
  logic [TW-1:0]   tcnt, tcnt_n;
  logic            tick;
  logic [3:0]      sub, sub_n;
  logic [2:0]      bitcnt, bitcnt_n;
  logic [7:0]      shift, shift_n;
  logic            armed, armed_n;
  logic            load, ferr_set;

  assign tick = (state != IDLE) && (tcnt == TW'(DIV - 1));
  assign busy = (state != IDLE);

  always_comb begin
    state_n  = state;
    sub_n    = sub;
    bitcnt_n = bitcnt;
    shift_n  = shift;
    armed_n  = 1'b0;
    load     = 1'b0;
    ferr_set = 1'b0;
    tcnt_n   = (state == IDLE || tick) ? '0 : tcnt + 1'b1;
    unique case (state)
      IDLE: begin
        // armed only re-arms after the line has been seen high, so a held-low
        // line (break or post-error) cannot start a new frame
        armed_n = armed | rx_s;
        if (armed && !rx_s) begin
          state_n  = START;
          sub_n    = '0;
          bitcnt_n = '0;
          armed_n  = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          if (sub == 4'd7) begin
            sub_n    = '0;
            bitcnt_n = '0;
            state_n  = rx_s ? IDLE : DATA;
          end else begin
            sub_n = sub + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          sub_n = sub + 1'b1;
          if (sub == 4'd15) begin
            shift_n  = {rx_s, shift[7:1]};
            bitcnt_n = bitcnt + 1'b1;
            if (bitcnt == 3'd7) state_n = STOP;
          end
        end
      end
      STOP: begin
        if (tick) begin
          sub_n = sub + 1'b1;
          if (sub == 4'd15) begin
            state_n  = IDLE;
            load     = rx_s;
            ferr_set = !rx_s;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      sync1  <= 1'b1;
      rx_s   <= 1'b1;
      tcnt   <= '0;
      sub    <= '0;
      bitcnt <= '0;
      shift  <= '0;
      armed  <= 1'b0;
    end else begin
      state  <= state_n;
      sync1  <= DataIn;
      rx_s   <= sync1;
      tcnt   <= tcnt_n;
      sub    <= sub_n;
      bitcnt <= bitcnt_n;
      shift  <= shift_n;
      armed  <= armed_n;
    end
  end

  // A load takes priority over a same-cycle acknowledge; set beats clear on flags.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      DataOut  <= '0;
      charRX   <= 1'b0;
      frameErr <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (load) begin
        DataOut <= shift;
        charRX  <= 1'b1;
      end else if (rdAck && charRX) begin
        charRX <= 1'b0;
      end

      if (load && charRX && !rdAck) overrun <= 1'b1;
      else if (rdAck)               overrun <= 1'b0;

      if (ferr_set)   frameErr <= 1'b1;
      else if (rdAck) frameErr <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl at a reduced bit period (DIV=5, 80 clocks/bit).
module tb_uart_rx_ctrl;

  localparam int CLK_HZ = 50000000;
  localparam int BAUD   = 625000;
  localparam int DIV    = 5;
  localparam int BIT    = 16 * DIV;
  localparam int FRAME  = 10 * BIT;
  localparam int RISE   = 152 * DIV + 3;

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  logic       DataIn;
  logic       rdAck;
  logic [7:0] DataOut;
  logic       charRX, frameErr, overrun, busy;

  int n_checks = 0;
  int n_fail   = 0;
  int rise;

  uart_rx_ctrl #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(16)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .DataIn   (DataIn),
    .rdAck    (rdAck),
    .DataOut  (DataOut),
    .charRX   (charRX),
    .frameErr (frameErr),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic wait_clks(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives ncyc clocks of a frame; rise = clock count at which charRX went 0->1.
  task automatic send_frame(input logic [7:0] data, input logic stop, input int ack_at,
                            input int ncyc, output int r);
    logic [9:0] fr;
    logic       prev;
    fr   = {stop, data, 1'b0};
    r    = 0;
    prev = charRX;
    for (int c = 0; c < ncyc; c++) begin
      DataIn = fr[c / BIT];
      rdAck  = (c == ack_at);
      wait_clks(1);
      if (charRX && !prev && r == 0) r = c + 1;
      prev = charRX;
    end
    rdAck = 1'b0;
  endtask

  task automatic ack_pulse();
    rdAck = 1'b1;
    wait_clks(1);
    rdAck = 1'b0;
  endtask

  initial begin
    reset  = 1'b0;
    DataIn = 1'b1;
    rdAck  = 1'b0;
    wait_clks(3);
    check("rst_dataout", DataOut, 8'h00);
    check("rst_charrx", charRX, 1'b0);
    check("rst_frameerr", frameErr, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_busy", busy, 1'b0);
    reset = 1'b1;
    wait_clks(BIT);

    // good frame
    send_frame(8'hA5, 1'b1, -1, FRAME, rise);
    check("a5_rise", rise, RISE);
    check("a5_data", DataOut, 8'hA5);
    check("a5_charrx", charRX, 1'b1);
    check("a5_frameerr", frameErr, 1'b0);
    check("a5_overrun", overrun, 1'b0);
    check("a5_busy", busy, 1'b0);
    ack_pulse();
    check("a5_ack_charrx", charRX, 1'b0);
    check("a5_ack_data", DataOut, 8'hA5);
    ack_pulse();
    check("idle_ack_charrx", charRX, 1'b0);

    // start glitch of 3 ticks
    DataIn = 1'b0;
    wait_clks(5);
    check("glitch_busy_hi", busy, 1'b1);
    wait_clks(10);
    DataIn = 1'b1;
    wait_clks(45);
    check("glitch_busy_lo", busy, 1'b0);
    check("glitch_charrx", charRX, 1'b0);
    check("glitch_frameerr", frameErr, 1'b0);
    check("glitch_data", DataOut, 8'hA5);

    // framing error then held-low line
    send_frame(8'h3C, 1'b0, -1, FRAME, rise);
    check("ferr_flag", frameErr, 1'b1);
    wait_clks(20 * BIT);
    check("ferr_hold_busy", busy, 1'b0);
    check("ferr_hold_flag", frameErr, 1'b1);
    check("ferr_charrx", charRX, 1'b0);
    check("ferr_data", DataOut, 8'hA5);
    DataIn = 1'b1;
    wait_clks(2 * BIT);
    send_frame(8'h3C, 1'b1, -1, FRAME, rise);
    check("rec_rise", rise, RISE);
    check("rec_data", DataOut, 8'h3C);
    check("rec_charrx", charRX, 1'b1);
    check("rec_ferr_sticky", frameErr, 1'b1);
    ack_pulse();
    check("rec_ack_charrx", charRX, 1'b0);
    check("rec_ack_ferr", frameErr, 1'b0);

    // back-to-back without acknowledge
    send_frame(8'h11, 1'b1, -1, FRAME, rise);
    send_frame(8'h22, 1'b1, -1, FRAME, rise);
    check("ovr_data", DataOut, 8'h22);
    check("ovr_charrx", charRX, 1'b1);
    check("ovr_flag", overrun, 1'b1);
    check("ovr_ferr", frameErr, 1'b0);
    ack_pulse();
    check("ovr_ack_charrx", charRX, 1'b0);
    check("ovr_ack_flag", overrun, 1'b0);

    // acknowledge landing on the load clock
    send_frame(8'h11, 1'b1, -1, FRAME, rise);
    check("pend_data", DataOut, 8'h11);
    check("pend_overrun", overrun, 1'b0);
    send_frame(8'h33, 1'b1, RISE - 1, FRAME, rise);
    check("simul_charrx", charRX, 1'b1);
    check("simul_data", DataOut, 8'h33);
    check("simul_overrun", overrun, 1'b0);

    // reset in the middle of a frame
    send_frame(8'h5A, 1'b1, -1, 400, rise);
    check("mid_busy", busy, 1'b1);
    reset = 1'b0;
    #1;
    check("mid_rst_data", DataOut, 8'h00);
    check("mid_rst_charrx", charRX, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_ferr", frameErr, 1'b0);
    check("mid_rst_ovr", overrun, 1'b0);
    DataIn = 1'b1;
    wait_clks(3);
    reset = 1'b1;
    wait_clks(2 * BIT);
    check("post_rst_charrx", charRX, 1'b0);
    check("post_rst_busy", busy, 1'b0);
    send_frame(8'h5A, 1'b1, -1, FRAME, rise);
    check("post_rst_rise", rise, RISE);
    check("post_rst_data", DataOut, 8'h5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
